// File: rtl/wisc_pkg.sv
// Shared WISC types: opcodes, flag bit positions, halt FSM states.
// Used by the EX/MEM stage and its flag logic.
package wisc_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LLB    = 4'hA,
    OP_LHB    = 4'hB,
    OP_B      = 4'hC,
    OP_BR     = 4'hD,
    OP_PCS    = 4'hE,
    OP_HLT    = 4'hF
  } opcode_t;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } halt_state_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX -> MEM bundle: EX-side inputs and registered MEM-side outputs.
// master drives EX fields, slave is the pipeline stage.
interface ex_mem_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
);
  logic              ex_valid;
  logic [3:0]        ex_opcode;
  logic [DATA_W-1:0] ex_result;
  logic              ex_ovfl;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_we;

  logic              mem_valid;
  logic [3:0]        mem_opcode;
  logic [DATA_W-1:0] mem_result;
  logic [DATA_W-1:0] mem_store_data;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_we;

  modport master (
    output ex_valid, ex_opcode, ex_result,
    output ex_ovfl, ex_store_data, ex_rd, ex_we,
    input  mem_valid, mem_opcode, mem_result,
    input  mem_store_data, mem_rd, mem_we
  );

  modport slave (
    input  ex_valid, ex_opcode, ex_result,
    input  ex_ovfl, ex_store_data, ex_rd, ex_we,
    output mem_valid, mem_opcode, mem_result,
    output mem_store_data, mem_rd, mem_we
  );
endinterface

// File: rtl/ex_mem_stage_flag_logic.sv
// Next N/Z/V flag value for an opcode; shared by the flag register
// and the forwarding path.
module flag_logic
  import wisc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] result,
  input  logic              ovfl,
  input  logic [2:0]        flags_cur,
  output logic [2:0]        flags_nxt
);

  logic arith;
  logic z_only;

  assign arith  = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign z_only = (opcode == OP_XOR) || (opcode == OP_SLL)
               || (opcode == OP_SRA) || (opcode == OP_ROR);

  always_comb begin
    flags_nxt = flags_cur;
    unique case (1'b1)
      arith: begin
        flags_nxt[FLAG_Z] = (result == '0);
        flags_nxt[FLAG_V] = ovfl;
        flags_nxt[FLAG_N] = result[DATA_W-1];
      end
      z_only: flags_nxt[FLAG_Z] = (result == '0);
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with N/Z/V flags and halt FSM.
// Optional FLAG_FWD_EN adds the combinational flags_fwd output.
module ex_mem_stage
  import wisc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  ex_mem_stage_if.slave bus,
  output logic [2:0]   flags,
`ifdef FLAG_FWD_EN
  output logic [2:0]   flags_fwd,
`endif
  output logic         halted
);

  halt_state_t state, state_nxt;

  logic              cap;
  logic [2:0]        flags_q;
  logic [2:0]        flags_nxt;
  logic              valid_q;
  logic [3:0]        opcode_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] sdata_q;
  logic [REG_AW-1:0] rd_q;
  logic              we_q;

  assign cap = bus.ex_valid & ~stall & ~flush
             & (state == ST_RUN);

  flag_logic #(.DATA_W(DATA_W)) u_flag (
    .opcode    (bus.ex_opcode),
    .result    (bus.ex_result),
    .ovfl      (bus.ex_ovfl),
    .flags_cur (flags_q),
    .flags_nxt (flags_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN:    if (cap && bus.ex_opcode == OP_HLT)
                   state_nxt = ST_DRAIN;
      ST_DRAIN:  if (!stall) state_nxt = ST_HALTED;
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      opcode_q <= '0;
      result_q <= '0;
      sdata_q  <= '0;
      rd_q     <= '0;
      we_q     <= 1'b0;
      flags_q  <= '0;
    end else if (!stall) begin
      if (cap) begin
        valid_q  <= 1'b1;
        opcode_q <= bus.ex_opcode;
        result_q <= bus.ex_result;
        sdata_q  <= bus.ex_store_data;
        rd_q     <= bus.ex_rd;
        we_q     <= bus.ex_we;
        flags_q  <= flags_nxt;
      end else begin
        // bubble: keep payload, kill valid and write enable
        valid_q <= 1'b0;
        we_q    <= 1'b0;
      end
    end
  end

  assign bus.mem_valid      = valid_q;
  assign bus.mem_opcode     = opcode_q;
  assign bus.mem_result     = result_q;
  assign bus.mem_store_data = sdata_q;
  assign bus.mem_rd         = rd_q;
  assign bus.mem_we         = we_q;
  assign flags              = flags_q;
  assign halted             = (state == ST_HALTED);

`ifdef FLAG_FWD_EN
  assign flags_fwd = cap ? flags_nxt : flags_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: reset, flags, stall/flush, halt.
// Build with FLAG_FWD_EN to also check flags_fwd.
module tb_ex_mem_stage;

  logic clk = 1'b0;
  logic rst;
  logic stall;
  logic flush;
  logic [2:0] flags;
  logic halted;
`ifdef FLAG_FWD_EN
  logic [2:0] flags_fwd;
`endif

  int tests = 0;
  int fails = 0;

  ex_mem_stage_if #(.DATA_W(16), .REG_AW(4)) bus ();

  ex_mem_stage #(.DATA_W(16), .REG_AW(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .stall  (stall),
    .flush  (flush),
    .bus    (bus.slave),
    .flags  (flags),
`ifdef FLAG_FWD_EN
    .flags_fwd (flags_fwd),
`endif
    .halted (halted)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op,
                       input logic [15:0] res, input logic ov,
                       input logic [15:0] sd, input logic [3:0] rd,
                       input logic we);
    bus.ex_valid      = v;
    bus.ex_opcode     = op;
    bus.ex_result     = res;
    bus.ex_ovfl       = ov;
    bus.ex_store_data = sd;
    bus.ex_rd         = rd;
    bus.ex_we         = we;
  endtask

  initial begin
    // reset with garbage, including a HLT that must be ignored
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 4'hF, 16'hFFFF, 1'b1, 16'hBEEF, 4'hF, 1'b1);
    step();
    rst = 1'b0;
    chk("rst_valid",  {15'd0, bus.mem_valid}, 16'd0);
    chk("rst_opcode", {12'd0, bus.mem_opcode}, 16'd0);
    chk("rst_result", bus.mem_result, 16'd0);
    chk("rst_sdata",  bus.mem_store_data, 16'd0);
    chk("rst_rd",     {12'd0, bus.mem_rd}, 16'd0);
    chk("rst_we",     {15'd0, bus.mem_we}, 16'd0);
    chk("rst_flags",  {13'd0, flags}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);

    // ADD 8000 with overflow -> Z=0 V=1 N=1
    drive(1'b1, 4'h0, 16'h8000, 1'b1, 16'h1234, 4'h3, 1'b1);
    step();
    chk("add_valid",  {15'd0, bus.mem_valid}, 16'd1);
    chk("add_result", bus.mem_result, 16'h8000);
    chk("add_opcode", {12'd0, bus.mem_opcode}, 16'h0);
    chk("add_sdata",  bus.mem_store_data, 16'h1234);
    chk("add_rd",     {12'd0, bus.mem_rd}, 16'h3);
    chk("add_we",     {15'd0, bus.mem_we}, 16'd1);
    chk("add_flags",  {13'd0, flags}, 16'b011);

    // XOR result 0: only Z changes
    drive(1'b1, 4'h2, 16'h0000, 1'b0, 16'h0, 4'h4, 1'b1);
    step();
    chk("xor_flags",  {13'd0, flags}, 16'b111);
    chk("xor_result", bus.mem_result, 16'h0000);

    // PADDSB result 0: no flag change
    drive(1'b1, 4'h7, 16'h0000, 1'b0, 16'h0, 4'h5, 1'b1);
    step();
    chk("paddsb_flags",  {13'd0, flags}, 16'b111);
    chk("paddsb_opcode", {12'd0, bus.mem_opcode}, 16'h7);

    // SUB result 1: clears all flags
    drive(1'b1, 4'h1, 16'h0001, 1'b0, 16'h5555, 4'h6, 1'b1);
    step();
    chk("sub_flags",  {13'd0, flags}, 16'b000);
    chk("sub_result", bus.mem_result, 16'h0001);

    // stall with flush and a new ADD: everything holds
    stall = 1'b1; flush = 1'b1;
    drive(1'b1, 4'h0, 16'h0000, 1'b1, 16'hAAAA, 4'h9, 1'b1);
`ifdef FLAG_FWD_EN
    #1;
    chk("stall_fwd", {13'd0, flags_fwd}, 16'b000);
`endif
    for (int i = 0; i < 3; i++) step();
    chk("stall_valid",  {15'd0, bus.mem_valid}, 16'd1);
    chk("stall_opcode", {12'd0, bus.mem_opcode}, 16'h1);
    chk("stall_result", bus.mem_result, 16'h0001);
    chk("stall_rd",     {12'd0, bus.mem_rd}, 16'h6);
    chk("stall_we",     {15'd0, bus.mem_we}, 16'd1);
    chk("stall_flags",  {13'd0, flags}, 16'b000);

    // drop stall, flush still high: bubble
    stall = 1'b0;
    step();
    chk("flush_valid",  {15'd0, bus.mem_valid}, 16'd0);
    chk("flush_we",     {15'd0, bus.mem_we}, 16'd0);
    chk("flush_result", bus.mem_result, 16'h0001);
    chk("flush_flags",  {13'd0, flags}, 16'b000);

    // SUB result 0: forward path sees Z before the register does
    flush = 1'b0;
    drive(1'b1, 4'h1, 16'h0000, 1'b0, 16'h0, 4'h2, 1'b1);
    #1;
`ifdef FLAG_FWD_EN
    chk("fwd_z",     {13'd0, flags_fwd}, 16'b100);
`endif
    chk("fwd_old",   {13'd0, flags}, 16'b000);
    step();
    chk("sub0_flags", {13'd0, flags}, 16'b100);

    // invalid EX: bubble, flags hold
    drive(1'b0, 4'h0, 16'h8000, 1'b1, 16'h0, 4'h1, 1'b1);
    step();
    chk("inv_valid", {15'd0, bus.mem_valid}, 16'd0);
    chk("inv_flags", {13'd0, flags}, 16'b100);

    // HLT captured, then stall two cycles: HLT stays visible
    drive(1'b1, 4'hF, 16'h0000, 1'b0, 16'h0, 4'h0, 1'b0);
    step();
    chk("hlt_valid",  {15'd0, bus.mem_valid}, 16'd1);
    chk("hlt_opcode", {12'd0, bus.mem_opcode}, 16'hF);
    chk("hlt_halted", {15'd0, halted}, 16'd0);
    stall = 1'b1;
    drive(1'b1, 4'h0, 16'h8000, 1'b1, 16'h0, 4'h7, 1'b1);
    step();
    step();
    chk("drain_valid",  {15'd0, bus.mem_valid}, 16'd1);
    chk("drain_opcode", {12'd0, bus.mem_opcode}, 16'hF);
    chk("drain_halted", {15'd0, halted}, 16'd0);
    stall = 1'b0;
    step();
    chk("halt_halted", {15'd0, halted}, 16'd1);
    chk("halt_valid",  {15'd0, bus.mem_valid}, 16'd0);
    step();
    step();
    chk("halt_hold_valid",  {15'd0, bus.mem_valid}, 16'd0);
    chk("halt_hold_opcode", {12'd0, bus.mem_opcode}, 16'hF);
    chk("halt_hold_flags",  {13'd0, flags}, 16'b100);
    chk("halt_hold_halted", {15'd0, halted}, 16'd1);

    // reset leaves HALTED and clears flags
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_halted", {15'd0, halted}, 16'd0);
    chk("rst2_flags",  {13'd0, flags}, 16'b000);
    chk("rst2_valid",  {15'd0, bus.mem_valid}, 16'd0);

    // back in RUN: ADD captures again
    step();
    chk("run_valid",  {15'd0, bus.mem_valid}, 16'd1);
    chk("run_result", bus.mem_result, 16'h8000);
    chk("run_flags",  {13'd0, flags}, 16'b011);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
